// File: rtl/md_pkg.sv
// Shared constants, state encoding and op-classification helpers for the
// iterative RV32M multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Plain-vector aliases so the state register can stay a legacy logic vector.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_sign_prep.sv
// Operand magnitude / sign-flag generation on the way in, and sign fix-up plus
// result selection on the way out of the iterative datapath.
module md_sign_prep
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              res_neg,
    output logic              rem_neg,
    input  logic [2:0]        fix_op,
    input  logic              fix_res_neg,
    input  logic              fix_rem_neg,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   fix_result
);

    logic              neg_a;
    logic              neg_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    assign neg_a   = is_signed_a(op) & op_a[XLEN-1];
    assign neg_b   = is_signed_b(op) & op_b[XLEN-1];
    assign mag_a   = neg_a ? -op_a : op_a;
    assign mag_b   = neg_b ? -op_b : op_b;
    assign res_neg = neg_a ^ neg_b;
    assign rem_neg = neg_a;

    // The whole double-width product is negated before the high half is taken,
    // otherwise the borrow out of the low half would be lost.
    assign prod_fix = fix_res_neg ? -acc : acc;
    assign quot_fix = fix_res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = fix_rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_result = acc[XLEN-1:0];
        case (fix_op)
            MD_MUL:                       fix_result = acc[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_result = quot_fix;
            MD_REM, MD_REMU:              fix_result = rem_fix;
            default:                      fix_result = acc[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide sharing one double-width accumulator, one bit per cycle.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_reg,   state_next;
    logic [2:0]        op_reg,      op_next;
    logic              neg_reg,     neg_next;
    logic              neg_rem_reg, neg_rem_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [2*XLEN-1:0] acc_reg,     acc_next;
    logic [XLEN-1:0]   b_reg,       b_next;
    logic [XLEN-1:0]   result_reg,  result_next;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              prep_neg;
    logic              prep_rem_neg;
    logic [XLEN-1:0]   fix_result;

    logic              div_zero;
    logic              overflow;
    logic              special;
    logic [XLEN-1:0]   special_result;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] acc_step;
    logic              last_iter;

    md_sign_prep #(
        .XLEN (XLEN)
    ) u_sign_prep (
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .res_neg     (prep_neg),
        .rem_neg     (prep_rem_neg),
        .fix_op      (op_reg),
        .fix_res_neg (neg_reg),
        .fix_rem_neg (neg_rem_reg),
        .acc         (acc_step),
        .fix_result  (fix_result)
    );

    // Divide-by-zero and signed overflow are resolved straight from the ports.
    assign div_zero = (op_b == '0);
    assign overflow = ((op == MD_DIV) || (op == MD_REM)) && (op_a == MIN_INT) && (op_b == '1);
    assign special  = is_div(op) && (div_zero || overflow);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = ((op == MD_DIV) || (op == MD_DIVU)) ? '1 : op_a;
        end else if (overflow) begin
            special_result = (op == MD_DIV) ? MIN_INT : '0;
        end
    end

    // Multiply: conditional add into the high half, then shift the pair right.
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, b_reg};
    assign mul_step = acc_reg[0] ? {mul_sum, acc_reg[XLEN-1:1]}
                                 : {1'b0, acc_reg[2*XLEN-1:1]};

    // Divide: {remainder, dividend} shifts left; a borrow means restore.
    assign div_trial = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, b_reg};
    assign div_step  = div_trial[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};

    assign acc_step  = is_div(op_reg) ? div_step : mul_step;
    assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        neg_next     = neg_reg;
        neg_rem_next = neg_rem_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        b_next       = b_reg;
        result_next  = result_reg;
        if (flush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_next      = op;
                        neg_next     = prep_neg;
                        neg_rem_next = prep_rem_neg;
                        cnt_next     = '0;
                        acc_next     = {{XLEN{1'b0}}, mag_a};
                        b_next       = mag_b;
                        if (special) begin
                            state_next  = ST_DONE;
                            result_next = special_result;
                        end else begin
                            state_next  = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_next = acc_step;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        state_next  = ST_DONE;
                        cnt_next    = '0;
                        result_next = fix_result;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            neg_reg     <= 1'b0;
            neg_rem_reg <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            neg_reg     <= neg_next;
            neg_rem_reg <= neg_rem_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            b_reg       <= b_next;
            result_reg  <= result_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit at XLEN=32 and XLEN=8 against
// an arithmetic reference model of the RV32M rules.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;

    logic        flush8 = 1'b0;
    logic        in_valid8 = 1'b0;
    logic        out_ready8 = 1'b1;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  op_a8 = '0;
    logic [7:0]  op_b8 = '0;
    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  result8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          w8;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          hold;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .op        (op8),
        .op_a      (op_a8),
        .op_b      (op_b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .result    (result8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with wide integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [31:0] mask;
        longint      ua, ub, sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = longint'(a & mask);
        ub = longint'(b & mask);
        sa = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb = b[w-1] ? ub - (longint'(1) << w) : ub;
        r = '0;
        case (o)
            3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); p = p >> w; r = p[31:0]; end
            3'd2: begin p = 64'(sa * ub); p = p >> w; r = p[31:0]; end
            3'd3: begin p = 64'(ua * ub); p = p >> w; r = p[31:0]; end
            3'd4: r = (ub == 0) ? mask : 32'(sa / sb);
            3'd5: r = (ub == 0) ? mask : 32'(ua / ub);
            3'd6: r = (ub == 0) ? a    : 32'(sa % sb);
            default: r = (ub == 0) ? a : 32'(ua % ub);
        endcase
        return r & mask;
    endfunction

    function automatic logic obs_valid(input bit w8);
        return w8 ? out_valid8 : out_valid;
    endfunction

    function automatic logic obs_in_ready(input bit w8);
        return w8 ? in_ready8 : in_ready;
    endfunction

    function automatic logic [31:0] obs_result(input bit w8);
        return w8 ? {24'd0, result8} : result;
    endfunction

    task automatic drive(input bit w8, input logic v, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic rdy);
        if (w8) begin
            in_valid8 = v; op8 = o; op_a8 = a[7:0]; op_b8 = b[7:0]; out_ready8 = rdy;
            in_valid = 1'b0;
        end else begin
            in_valid = v; op = o; op_a = a; op_b = b; out_ready = rdy;
            in_valid8 = 1'b0;
        end
    endtask

    // One complete transaction; called #1 after a rising edge.
    task automatic do_op(input bit w8, input logic [2:0] o, input logic [31:0] a_in,
                         input logic [31:0] b_in, input int hold, output logic [31:0] got);
        int          w;
        logic [31:0] mask, a, b, exp;
        int          lat, exp_lat;
        bit          spec;
        w    = w8 ? 8 : 32;
        mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        exp  = ref_md(o, a, b, w);
        spec = o[2] && ((b == 0) || (((o == 3'd4) || (o == 3'd6)) &&
                        (a == (32'd1 << (w - 1))) && (b == mask)));
        exp_lat = spec ? 1 : w + 1;
        check("idle_in_ready", 64'(obs_in_ready(w8)), 64'd1);
        drive(w8, 1'b1, o, a, b, hold == 0);
        @(posedge clk); #1;
        drive(w8, 1'b0, 3'($urandom), $urandom, $urandom, hold == 0);
        lat = 1;
        while (!obs_valid(w8) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        got = obs_result(w8);
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", 64'(got), 64'(exp));
        check("busy_in_ready", 64'(obs_in_ready(w8)), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(obs_valid(w8)), 64'd1);
            check("hold_result", 64'(obs_result(w8)), 64'(exp));
            check("hold_in_ready", 64'(obs_in_ready(w8)), 64'd0);
        end
        drive(w8, 1'b0, o, a, b, 1'b1);
        @(posedge clk); #1;
        check("post_valid", 64'(obs_valid(w8)), 64'd0);
        check("post_in_ready", 64'(obs_in_ready(w8)), 64'd1);
        $display("xlen=%0d op=%0d a=%h b=%h result=%h expected=%h latency=%0d hold=%0d",
                 w, o, a, b, got, exp, lat, hold);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] got;
        bit          seen;

        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset8_in_ready", 64'(in_ready8), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{1'b0, 3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0});
        vecs.push_back('{1'b0, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0});
        vecs.push_back('{1'b0, 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0});
        vecs.push_back('{1'b0, 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0});
        vecs.push_back('{1'b0, 3'd5, 32'd100,        32'd7,         32'd14,        0});
        vecs.push_back('{1'b0, 3'd7, 32'd100,        32'd7,         32'd2,         0});
        vecs.push_back('{1'b0, 3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0});
        vecs.push_back('{1'b0, 3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0});
        vecs.push_back('{1'b0, 3'd4, 32'd55,         32'd0,         32'hFFFF_FFFF, 0});
        vecs.push_back('{1'b0, 3'd7, 32'h1234,       32'd0,         32'h1234,      0});
        vecs.push_back('{1'b0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0});
        vecs.push_back('{1'b0, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0});
        vecs.push_back('{1'b0, 3'd5, 32'd1000,       32'd9,         32'd111,       5});
        vecs.push_back('{1'b0, 3'd0, 32'd3,          32'd5,         32'd15,        0});
        vecs.push_back('{1'b1, 3'd5, 32'd200,        32'd3,         32'd66,        0});
        vecs.push_back('{1'b1, 3'd0, 32'h10,         32'h10,        32'h00,        0});
        vecs.push_back('{1'b1, 3'd3, 32'h10,         32'h10,        32'h01,        0});
        foreach (vecs[i]) begin
            do_op(vecs[i].w8, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].hold, got);
            check("directed_value", 64'(got), 64'(vecs[i].e));
        end

        for (int i = 0; i < 60; i++) begin
            do_op(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(),
                  int'($urandom_range(0, 2)), got);
        end

        // Flush part-way through CALC: the op must vanish without an output.
        drive(1'b0, 1'b1, 3'd5, 32'd1000, 32'd3, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_output", 64'(seen), 64'd0);
        $display("flush during CALC: out_valid seen=%0d", seen);

        // Flush wins over a simultaneous accept in IDLE.
        drive(1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_no_accept", 64'(in_ready), 64'd1);
        $display("flush in IDLE with in_valid: in_ready=%0d", in_ready);

        // Flush wins over the output handshake in DONE.
        drive(1'b0, 1'b1, 3'd5, 32'd9, 32'd0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("special_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_done_valid", 64'(out_valid), 64'd0);
        check("flush_done_in_ready", 64'(in_ready), 64'd1);
        $display("flush in DONE: out_valid=%0d", out_valid);

        // Asynchronous reset in the middle of CALC.
        do_op(1'b0, 3'd0, 32'd6, 32'd7, 0, got);
        drive(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_output", 64'(seen), 64'd0);
        $display("reset during CALC: result=%h out_valid seen=%0d", result, seen);
        do_op(1'b0, 3'd6, 32'hFFFF_FF9C, 32'd7, 0, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in XLEN; the multi-cycle successor to the single-cycle ALU decode/select path.
- Sits beside the ALU in the execute stage. The ALU control decode issues it an op (funct3) with operands through a valid/ready handshake.
- Returns one result through an output valid/ready handshake.
- Handles the RISC-V divide-by-zero and signed-overflow rules in one cycle, with no iteration.

Parameters:
- XLEN, 32: operand and result width; must be at least 2.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight op.
- in_valid  input  1  op/operands valid.
- in_ready  output  1  unit can accept an op.
- op  input  3  funct3 encoding (see Behaviour).
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  rd value.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Op encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath registers 0. Reset mid-operation discards the op with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready at the clock edge.
  - On accept: latch the op; latch magnitudes of op_a/op_b for the signed ops (MULH/DIV/REM: both operands; MULHSU: op_a only); latch the result-sign flag; counter=0.
- Special cases on accept (divide ops only; next state DONE):
  - op_b=0: DIV/DIVU result all-ones; REM/REMU result op_a.
  - Signed overflow, DIV/REM with op_a=MIN_INT and op_b=all-ones: DIV result MIN_INT, REM result 0.
  - All other accepted ops go to CALC.
- CALC:
  - One iteration per cycle.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - After exactly XLEN iterations, transition to DONE.
  - Sign fix-up and result select are registered on that transition:
    - MUL: low half of the product.
    - MULH/MULHSU/MULHU: high half, negated first if the sign flag is set.
    - DIV: quotient, negated if the operand signs differ.
    - REM: remainder, with the sign of op_a.
    - Unsigned ops: no sign fix-up.
- DONE:
  - out_valid=1; result held stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE.
  - in_ready is 0 in CALC and DONE, so no accept occurs in the same cycle as the output handshake. The next op is accepted at the earliest one cycle later.
- Latency, accept edge to first cycle with out_valid=1:
  - Normal ops: XLEN+1 cycles (XLEN CALC cycles, then DONE).
  - Special cases: 1 cycle.
- Throughput: one op per XLEN+2 cycles with out_ready tied high.
- flush:
  - In any state, the next state is IDLE and out_valid=0 on the next cycle; the result is discarded.
  - flush has priority over accept and over the output handshake in the same cycle.
  - flush in IDLE with in_valid=1 does not accept.
- All arithmetic is modulo 2^XLEN for results and modulo 2^(2*XLEN) in the accumulator. Negation of MIN_INT magnitudes wraps.
- op_a/op_b/op are sampled only at accept; later changes are ignored.

Decomposition:
- Shared package md_pkg holds:
  - MD_MUL..MD_REMU funct3 constants.
  - State enum md_state_t {IDLE, CALC, DONE}.
  - Helper function is_div(op) (op[2]).
  - Helper function is_signed_a(op), is_signed_b(op).
- One sub-module, md_sign_prep: combinational magnitude/sign-flag generation from op_a, op_b, op. It is reused for the output fix-up select.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), XLEN=32 -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. All 33-cycle latency.
- DIV x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Each has out_valid 1 cycle after accept.
- Backpressure: out_ready low for 5 cycles in DONE -> result and out_valid held, in_ready=0 throughout. out_ready high -> IDLE next cycle. A second op is accepted the following cycle and returns the correct result.
- flush asserted at CALC iteration 10 -> IDLE next cycle, out_valid never rises, in_ready=1. rst_n pulsed low mid-CALC -> all outputs at reset values immediately (asynchronous).
- Parameter sweep XLEN=8: DIVU 200/3 -> 66 at latency 9. MUL 0x10 × 0x10 -> 0x00. MULHU 0x10 × 0x10 -> 0x01.
